// File: rtl/taus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | taus_pkg                                                                 |
// | Shared types, seed limits and seed sanitising for the tausworthe sched.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package taus_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WARM  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] c_s1_min = 32'd2;
    localparam logic [31:0] c_s2_min = 32'd8;
    localparam logic [31:0] c_s3_min = 32'd16;

    localparam logic [31:0] c_seed1_dflt = 32'h0000_1234;
    localparam logic [31:0] c_seed2_dflt = 32'h0000_5678;
    localparam logic [31:0] c_seed3_dflt = 32'h0009_ABCD;

    // Components below their minimum would lock the generator; each falls back independently.
    function automatic logic [95:0] sanitise_seed(input logic [95:0] seed,
                                                  input logic [95:0] fallback);
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
        s1 = (seed[31:0]  < c_s1_min) ? fallback[31:0]  : seed[31:0];
        s2 = (seed[63:32] < c_s2_min) ? fallback[63:32] : seed[63:32];
        s3 = (seed[95:64] < c_s3_min) ? fallback[95:64] : seed[95:64];
        return {s3, s2, s1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/taus_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | taus_rr_arb                                                              |
// | Rotating-priority arbiter: first eligible index at or above pointer.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module taus_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IW-1:0]    pointer,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    index
);

    localparam int IWP = IW + 1;

    logic [IW:0] w_cand;
    logic        w_found;

    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, pointer} + IWP'(k);
            if (w_cand >= IWP'(N_REQ)) begin
                w_cand = w_cand - IWP'(N_REQ);
            end
            if (enable && !w_found && eligible[w_cand[IW-1:0]]) begin
                w_found                = 1'b1;
                grant[w_cand[IW-1:0]]  = 1'b1;
                index                  = w_cand[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/taus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | taus_sched                                                               |
// | Seeds, warms up and round-robin shares one tausworthe generator.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module taus_sched
    import taus_pkg::*;
#(
    parameter int          N_REQ  = 4,
    parameter int          WARMUP = 16,
    parameter logic [31:0] SEED1  = c_seed1_dflt,
    parameter logic [31:0] SEED2  = c_seed2_dflt,
    parameter logic [31:0] SEED3  = c_seed3_dflt
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_wr,
    input  logic [95:0]       seed_in,
    output logic              busy,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  ack,
    output logic [31:0]       rnd_out,
    output logic              err_spur,
    output logic              gen_load,
    output logic [95:0]       gen_seed,
    output logic              gen_step,
    input  logic [31:0]       gen_out,
    input  logic              gen_valid
);

    localparam int          IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0] c_last  = IW'(N_REQ - 1);
    localparam logic [7:0]  c_warmup  = 8'(WARMUP);
    localparam logic [95:0] c_dflt    = {SEED3, SEED2, SEED1};

    state_t           r_state;
    logic [7:0]       r_step_cnt;
    logic [7:0]       r_valid_cnt;
    logic             r_pend;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic             r_step_d;
    logic [95:0]      r_seed_pend;
    logic [95:0]      r_gen_seed;
    logic             r_gen_load;
    logic             r_busy;
    logic             r_err;
    logic [N_REQ-1:0] r_ack;
    logic [31:0]      r_rnd;

    logic [N_REQ-1:0] w_own_mask;
    logic [N_REQ-1:0] w_elig;
    logic             w_arb_en;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_run_step;
    logic             w_warm_step;
    logic             w_ret;
    logic             w_spur;

    always_comb begin
        w_own_mask = '0;
        if (r_pend) begin
            w_own_mask[r_owner] = 1'b1;
        end
    end

    assign w_elig = req & ~w_own_mask;
    // A grant may reuse the generator in the very cycle the previous word returns.
    assign w_arb_en = (r_state == S_RUN) && !rst && !seed_wr && !r_gen_load
                      && (!r_pend || gen_valid);

    taus_rr_arb #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .eligible (w_elig),
        .pointer  (r_ptr),
        .enable   (w_arb_en),
        .grant    (w_grant),
        .index    (w_idx)
    );

    assign w_run_step  = |w_grant;
    assign w_warm_step = (r_state == S_WARM) && !r_gen_load && (r_step_cnt < c_warmup);
    assign w_ret       = gen_valid && r_pend;
    assign w_spur      = gen_valid && !r_step_d;

    assign gen_step = !rst && (w_warm_step || w_run_step);
    assign gen_load = r_gen_load;
    assign gen_seed = r_gen_seed;
    assign busy     = r_busy;
    assign err_spur = r_err;
    assign ack      = r_ack;
    assign rnd_out  = r_rnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_step_cnt  <= '0;
            r_valid_cnt <= '0;
            r_pend      <= 1'b0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_step_d    <= 1'b0;
            r_seed_pend <= c_dflt;
            r_gen_seed  <= c_dflt;
            r_gen_load  <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_ack       <= '0;
            r_rnd       <= '0;
        end else begin
            r_step_d   <= gen_step;
            r_ack      <= '0;
            r_gen_load <= 1'b0;

            if (w_spur) begin
                r_err <= 1'b1;
            end

            if (w_ret) begin
                r_ack[r_owner] <= 1'b1;
                r_rnd          <= gen_out;
            end

            if (w_run_step) begin
                r_pend  <= 1'b1;
                r_owner <= w_idx;
                r_ptr   <= (w_idx == c_last) ? '0 : w_idx + 1'b1;
            end else if (w_ret) begin
                r_pend <= 1'b0;
            end

            if (seed_wr) begin
                r_seed_pend <= sanitise_seed(seed_in, c_dflt);
            end

            case (r_state)
                S_LOAD: begin
                    if (!seed_wr) begin
                        r_gen_seed  <= r_seed_pend;
                        r_gen_load  <= 1'b1;
                        r_step_cnt  <= '0;
                        r_valid_cnt <= '0;
                        if (WARMUP == 0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_WARM;
                        end
                    end
                end
                S_WARM: begin
                    if (seed_wr) begin
                        r_state <= S_LOAD;
                    end else begin
                        if (w_warm_step) begin
                            r_step_cnt <= r_step_cnt + 8'd1;
                        end
                        if (gen_valid && r_step_d) begin
                            r_valid_cnt <= r_valid_cnt + 8'd1;
                            if (r_valid_cnt == c_warmup - 8'd1) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (seed_wr) begin
                        r_state <= S_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!r_pend || gen_valid) begin
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_taus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_taus_sched                                                            |
// | Randomised scoreboard bench with a behavioural scheduler model.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_taus_sched;

    localparam int          N      = 4;
    localparam int          WARMUP = 16;
    localparam logic [31:0] D1     = 32'h0000_1234;
    localparam logic [31:0] D2     = 32'h0000_5678;
    localparam logic [31:0] D3     = 32'h0009_ABCD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed_wr = 1'b0;
    logic [95:0]  seed_in = '0;
    logic [N-1:0] req = '0;
    logic         busy;
    logic [N-1:0] ack;
    logic [31:0]  rnd_out;
    logic         err_spur;
    logic         gen_load;
    logic [95:0]  gen_seed;
    logic         gen_step;
    logic [31:0]  gen_out = '0;
    logic         gen_valid = 1'b0;
    logic         force_spur = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  owner;
        logic [31:0] word;
    } exp_t;
    exp_t sb[$];

    taus_sched #(
        .N_REQ  (N),
        .WARMUP (WARMUP),
        .SEED1  (D1),
        .SEED2  (D2),
        .SEED3  (D3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_wr   (seed_wr),
        .seed_in   (seed_in),
        .busy      (busy),
        .req       (req),
        .ack       (ack),
        .rnd_out   (rnd_out),
        .err_spur  (err_spur),
        .gen_load  (gen_load),
        .gen_seed  (gen_seed),
        .gen_step  (gen_step),
        .gen_out   (gen_out),
        .gen_valid (gen_valid)
    );

    always #5 clk = ~clk;

    // Generator stand-in: answers each step one cycle later with a fresh random word.
    always @(posedge clk) begin
        gen_valid <= gen_step | force_spur;
        gen_out   <= $urandom;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] san(input logic [95:0] s);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = s[31:0];
        b = s[63:32];
        c = s[95:64];
        return {(c < 16) ? D3 : c, (b < 8) ? D2 : b, (a < 2) ? D1 : a};
    endfunction

    // Behavioural model of the scheduler, evaluated mid-cycle on settled inputs.
    localparam int P_LOAD = 0, P_WARM = 1, P_RUN = 2, P_DRAIN = 3;
    int          m_phase = P_LOAD;
    bit          m_loadp = 0;
    int          m_steps_left = 0;
    int          m_valids_left = 0;
    bit          m_busy = 1;
    bit          m_err = 0;
    bit          m_pend = 0;
    bit          m_step_prev = 0;
    int          m_owner = 0;
    int          m_ptr = 0;
    logic [95:0] m_seed_pend = {D3, D2, D1};
    logic [95:0] m_seed_exp = {D3, D2, D1};

    always @(negedge clk) begin
        int          g;
        bit          st;
        bit          nloadp;
        logic [N-1:0] elig;
        exp_t        e;
        if (rst) begin
            m_phase = P_LOAD; m_loadp = 0; m_busy = 1; m_err = 0;
            m_pend = 0; m_step_prev = 0; m_ptr = 0;
            m_seed_pend = {D3, D2, D1}; m_seed_exp = {D3, D2, D1};
        end else begin
            g = -1; st = 0; nloadp = 0;
            chk("gen_load", gen_load, m_loadp);
            if (m_loadp) chk("gen_seed", gen_seed, m_seed_exp);
            chk("busy", busy, m_busy);
            chk("err_spur", err_spur, m_err);
            case (m_phase)
                P_LOAD: begin
                    if (!seed_wr) begin
                        m_seed_exp = m_seed_pend;
                        nloadp = 1;
                        m_steps_left = WARMUP;
                        m_valids_left = WARMUP;
                        m_phase = P_WARM;
                    end
                end
                P_WARM: begin
                    st = !m_loadp && m_steps_left > 0;
                    if (seed_wr) begin
                        m_phase = P_LOAD;
                    end else begin
                        if (st) m_steps_left--;
                        if (gen_valid && m_step_prev) begin
                            m_valids_left--;
                            if (m_valids_left == 0) begin
                                m_phase = P_RUN;
                                m_busy = 0;
                            end
                        end
                    end
                end
                P_RUN: begin
                    elig = req;
                    if (m_pend) elig[m_owner] = 1'b0;
                    if (!seed_wr && !m_loadp && elig != 0 && (!m_pend || gen_valid)) begin
                        for (int k = 0; k < N; k++) begin
                            if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                        end
                    end
                    st = (g >= 0);
                    if (gen_valid && m_pend) begin
                        e.owner = 4'(m_owner);
                        e.word  = gen_out;
                        sb.push_back(e);
                    end
                    if (g >= 0) begin
                        m_pend = 1; m_owner = g; m_ptr = (g + 1) % N;
                    end else if (gen_valid) begin
                        m_pend = 0;
                    end
                    if (seed_wr) begin
                        m_phase = P_DRAIN;
                        m_busy = 1;
                    end
                end
                default: begin
                    if (!m_pend || gen_valid) begin
                        if (m_pend) begin
                            e.owner = 4'(m_owner);
                            e.word  = gen_out;
                            sb.push_back(e);
                        end
                        m_pend = 0;
                        m_phase = P_LOAD;
                    end
                end
            endcase
            chk("gen_step", gen_step, st);
            if (gen_valid && !m_step_prev) m_err = 1;
            m_step_prev = st;
            m_loadp = nloadp;
            if (seed_wr) m_seed_pend = san(seed_in);
        end
    end

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] oh;
        if (ack !== '0) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", ack, '0);
            end else begin
                e = sb.pop_front();
                oh = '0;
                oh[e.owner] = 1'b1;
                chk("ack_vec", ack, oh);
                chk("rnd_out", rnd_out, e.word);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_run(input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            cyc(1);
            k++;
        end
        chk("run_timeout", busy, 1'b0);
    endtask

    task automatic wait_load(input int limit);
        int k;
        k = 0;
        while (!gen_load && k < limit) begin
            cyc(1);
            k++;
        end
        chk("load_timeout", gen_load, 1'b1);
    endtask

    task automatic pulse_seed(input logic [95:0] s);
        seed_wr = 1'b1;
        seed_in = s;
        cyc(1);
        seed_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nsteps;
        int k;
        cyc(3);
        rst = 1'b0;
        chk("rst_ack", ack, '0);
        chk("rst_rnd", rnd_out, 32'd0);
        chk("rst_gen_seed", gen_seed, {D3, D2, D1});
        chk("rst_busy", busy, 1'b1);
        chk("rst_gen_load", gen_load, 1'b0);
        chk("rst_gen_step", gen_step, 1'b0);

        nsteps = 0;
        k = 0;
        while (busy && k < 200) begin
            if (gen_step) nsteps++;
            cyc(1);
            k++;
        end
        chk("warm_steps", nsteps, WARMUP);
        chk("warm_done", busy, 1'b0);

        req = 4'b1111;
        cyc(20);
        req = 4'b0100;
        cyc(12);
        req = 4'b0000;
        cyc(3);

        // Reseed while requester 1 has a word in flight.
        req = 4'b0010;
        cyc(1);
        req = 4'b1111;
        pulse_seed({32'd3, 32'd7, 32'd1});
        wait_load(20);
        chk("seed_fallback", gen_seed, {D3, D2, D1});
        wait_run(100);
        cyc(4);

        req = 4'b0000;
        cyc(2);
        pulse_seed({32'd20, 32'd8, 32'd2});
        wait_load(20);
        chk("seed_pass", gen_seed, {32'd20, 32'd8, 32'd2});
        cyc(4);
        pulse_seed({32'($urandom), 32'($urandom), 32'($urandom)});
        wait_run(100);

        for (int i = 0; i < 400; i++) begin
            req = N'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                seed_wr = 1'b1;
                seed_in = {32'($urandom_range(0, 31)), 32'($urandom_range(0, 15)),
                           32'($urandom_range(0, 3))};
            end else begin
                seed_wr = 1'b0;
            end
            cyc(1);
        end
        seed_wr = 1'b0;
        req = '0;
        wait_run(100);

        cyc(3);
        chk("err_clear", err_spur, 1'b0);
        force_spur = 1'b1;
        cyc(1);
        force_spur = 1'b0;
        cyc(2);
        chk("err_set", err_spur, 1'b1);
        cyc(5);
        chk("err_sticky", err_spur, 1'b1);

        req = 4'b0001;
        cyc(1);
        req = 4'b0000;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("rst_err", err_spur, 1'b0);
        chk("rst_mid_ack", ack, '0);
        wait_run(100);
        req = 4'b1010;
        cyc(10);
        req = '0;
        cyc(4);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/taus_sched.md
Name: taus_sched

Overview:
- Controller and round-robin arbiter that shares one tausworthe generator among N_REQ requesters.
- After reset or a reseed command it loads sanitised seeds into the generator and runs WARMUP discard steps.
- It then serves one 32-bit random word per granted request, routing each generator output back to its owner with a one-cycle ack.
- It sits between the tausworthe core and the consumer blocks: Monte-Carlo channels, noise injectors and test pattern sources.

Parameters:
- N_REQ, 4: number of requesters (2..16).
- WARMUP, 16: generator steps discarded after every seed load (0..255; 0 skips warm-up).
- SEED1, 32'h0000_1234: default/fallback seed for component s1.
- SEED2, 32'h0000_5678: default/fallback seed for component s2.
- SEED3, 32'h0009_ABCD: default/fallback seed for component s3.

Ports:
- clk, in, 1: system clock, all logic on rising edge.
- rst, in, 1: synchronous active-high reset.
- seed_wr, in, 1: one-cycle strobe; latch seed_in and reseed.
- seed_in, in, 96: {s3, s2, s1}.
- busy, out, 1: high while not in S_RUN.
- req, in, N_REQ: level request per requester; held until ack.
- ack, out, N_REQ: one-hot, one-cycle strobe; rnd_out is valid with it.
- rnd_out, out, 32: random word for the acked requester.
- err_spur, out, 1: sticky flag; gen_valid received with nothing outstanding.
- gen_load, out, 1: one-cycle seed load strobe to the generator.
- gen_seed, out, 96: sanitised seeds; held stable between loads.
- gen_step, out, 1: advance generator one step.
- gen_out, in, 32: generator output.
- gen_valid, in, 1: gen_out valid; arrives exactly one cycle after gen_step.

Behaviour:
- Reset values:
  - ack=0, rnd_out=0, gen_step=0, gen_load=0, err_spur=0, busy=1.
  - gen_seed={SEED3,SEED2,SEED1}; round-robin pointer at requester 0.
  - State S_LOAD; outstanding/owner cleared.
  - Reset mid-transaction drops the outstanding request; no ack is issued for it.
- Seed sanitisation, applied when seed_in is latched:
  - s1<2 is replaced by SEED1.
  - s2<8 is replaced by SEED2.
  - s3<16 is replaced by SEED3.
  - Each component is checked independently.
- FSM:
  - S_LOAD: gen_load=1 for exactly one cycle; go to S_WARM, or to S_RUN if WARMUP=0.
  - S_WARM: gen_step=1 on WARMUP consecutive cycles; count returned gen_valid; outputs discarded, no ack. After WARMUP valids, go to S_RUN (busy drops the same cycle the state changes).
  - S_RUN: arbitration as described below.
  - S_DRAIN: entered on seed_wr in S_RUN. No new grants; wait for the outstanding valid (still acked to its owner), then go to S_LOAD.
- seed_wr in S_LOAD/S_WARM/S_DRAIN: the new seed overwrites the latched one.
  - In S_LOAD/S_WARM: restart S_LOAD next cycle; in-flight warm-up valids are discarded.
  - In S_DRAIN: drain continues, then S_LOAD uses the newest seed.
- seed_wr coincident with rst: rst wins.
- Arbitration in S_RUN, each cycle:
  - Eligible = req with the pending owner's bit masked.
  - If eligible≠0 and (no outstanding, or gen_valid this cycle): grant the first eligible index searching upward from pointer with wrap; assert gen_step; record owner; set pointer = owner+1 mod N_REQ.
- Return:
  - On gen_valid with outstanding: rnd_out<=gen_out and ack[owner]<=1 in the same cycle (registered from gen_valid, so ack is 2 cycles after the grant).
  - rnd_out holds its value until the next ack.
- Throughput:
  - Aggregate up to 1 word/cycle.
  - A single requester gets at most 1 word per 2 cycles (it is masked while pending).
- A requester dropping req before ack still receives its ack/word; nothing is cancelled.
- gen_valid with nothing outstanding (S_RUN/S_DRAIN, or S_LOAD): set err_spur; data ignored; err_spur is cleared only by rst.

Decomposition:
- Shared package taus_pkg:
  - State enum {S_LOAD, S_WARM, S_RUN, S_DRAIN}.
  - Seed minima constants (2, 8, 16).
  - Default seed constants.
  - A seed-sanitise function.
- Sub-module taus_rr_arb: parameterised N_REQ rotating-priority arbiter with inputs eligible/pointer/enable and outputs one-hot grant and index.

Test Plan:
- Reset, no seed_wr -> gen_load pulse 1 cycle after rst release with gen_seed={0009ABCD,00005678,00001234}; exactly 16 gen_step; busy low after 16th valid; no ack during warm-up.
- seed_in={3,7,1} -> gen_seed={00000003... wait: s3=3<16, s2=7<8, s1=1<2} all replaced -> {0009ABCD,00005678,00001234}. seed_in={20,8,2} -> passed unchanged.
- req=4'b1111 held in S_RUN -> acks in order 0,1,2,3,0 at one per cycle after first; each rnd_out equals the gen_out of the preceding cycle.
- req=4'b0100 only -> ack[2] every 2nd cycle; gen_step duty 50%.
- seed_wr while requester 1 outstanding -> ack[1] still issued with its word; then busy=1, gen_load, 16 warm-up steps, no grants until S_RUN.
- Force gen_valid with no outstanding -> err_spur=1 and no ack; stays 1 until rst; rst during outstanding -> no ack afterward.
